mdio_phy_slave: RTL

//  PHY-side MDIO management target. It sits directly downstream of the MDIO master and

---
 rtl/mdio_pkg.sv | 33 +++
 rtl/mdio_edge_det.sv | 21 ++
 rtl/mdio_phy_slave.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared constants, field widths and FSM state encoding for the MDIO PHY target.
package mdio_pkg;

  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_READ    = 2'b10;
  localparam logic [1:0] ST_PATTERN = 2'b01;

  localparam int unsigned ST_W       = 2;
  localparam int unsigned OP_W       = 2;
  localparam int unsigned PHYAD_W    = 5;
  localparam int unsigned REGAD_W    = 5;
  localparam int unsigned TA_W       = 2;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned FRAME_BITS = 32;

  // Bit times left in the frame once a frame is known not to concern us.
  localparam logic [4:0] SKIP_AFTER_OP  = 5'(FRAME_BITS - ST_W - OP_W);
  localparam logic [4:0] SKIP_AFTER_PHY = 5'(FRAME_BITS - ST_W - OP_W - PHYAD_W);
  // Rises seen while driving: second TA bit plus every data bit.
  localparam logic [4:0] RD_RISES       = 5'(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OP,
    S_PHY,
    S_REG,
    S_TA,
    S_WDATA,
    S_RDATA,
    S_SKIP
  } mdio_state_e;

endpackage

// File: rtl/mdio_edge_det.sv
// Registers MDC in the clk domain and produces single-clk rise/fall pulses.
module mdio_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic mdc_i,
  output logic rise_o,
  output logic fall_o
);

  logic mdc_q;

  // Previous MDC level for edge detection.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) mdc_q <= 1'b0;
    else       mdc_q <= mdc_i;
  end

  assign rise_o = mdc_i & ~mdc_q;
  assign fall_o = ~mdc_i & mdc_q;

endmodule

// File: rtl/mdio_phy_slave.sv
// Clause-22 MDIO PHY target: frame decoder FSM, read shifter and register bank.
module mdio_phy_slave
  import mdio_pkg::*;
#(
  parameter logic [4:0]  PHY_ADDR = 5'd1,
  parameter int unsigned NUM_REGS = 8,
  parameter logic [31:0] PHY_ID   = 32'h0141_0CB0
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        MDC,
  input  logic        MDIO_OUT,
  input  logic        MDIO_OE,
  output logic        MDIO_IN,
  output logic        SLV_OE,
  output logic        WR_STROBE,
  output logic [4:0]  WR_ADDR,
  output logic [15:0] WR_DATA,
  output logic        FRAME_ERR
);

  localparam int unsigned IDXW       = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0]  NUM_REGS_L = 6'(NUM_REGS);

  mdio_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] sh_q, sh_d;
  logic [1:0]  hist_q, hist_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  regad_q, regad_d;
  logic        mdio_in_q, mdio_in_d;
  logic        slv_oe_q, slv_oe_d;
  logic        wr_strobe_q, wr_strobe_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_err_q, frame_err_d;
  logic [15:0] regs_q [NUM_REGS];
  logic [15:0] regs_d [NUM_REGS];
  logic [15:0] rd_word;
  logic        rise, fall, sample, commit;

  mdio_edge_det u_edge (
    .clk_i  (clk),
    .rst_i  (RESET),
    .mdc_i  (MDC),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign sample = rise & MDIO_OE;

  // Read word selection: ID registers, unimplemented space, then the bank.
  always_comb begin
    if (regad_q == 5'd2)                 rd_word = PHY_ID[31:16];
    else if (regad_q == 5'd3)            rd_word = PHY_ID[15:0];
    else if ({1'b0, regad_q} >= NUM_REGS_L) rd_word = '1;
    else                                 rd_word = regs_q[regad_q[IDXW-1:0]];
  end

  // Frame decoder: next state, shifter, counters and output registers.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    hist_d      = hist_q;
    is_read_d   = is_read_q;
    regad_d     = regad_q;
    mdio_in_d   = mdio_in_q;
    slv_oe_d    = slv_oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    commit      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!MDIO_OE) begin
          hist_d = '1;
        end else if (sample) begin
          hist_d = {hist_q[0], MDIO_OUT};
          if ({hist_q[0], MDIO_OUT} == ST_PATTERN) begin
            state_d = S_OP;
            cnt_d   = '0;
            hist_d  = '1;
          end
        end
      end
      S_OP, S_PHY, S_REG: begin
        if (!MDIO_OE) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sample) begin
          sh_d  = {sh_q[14:0], MDIO_OUT};
          cnt_d = cnt_q + 5'd1;
          if (state_q == S_OP && cnt_q == 5'(OP_W - 1)) begin
            cnt_d = '0;
            if ({sh_q[0], MDIO_OUT} == OP_WRITE) begin
              is_read_d = 1'b0;
              state_d   = S_PHY;
            end else if ({sh_q[0], MDIO_OUT} == OP_READ) begin
              is_read_d = 1'b1;
              state_d   = S_PHY;
            end else begin
              state_d     = S_SKIP;
              cnt_d       = SKIP_AFTER_OP;
              frame_err_d = 1'b1;
            end
          end else if (state_q == S_PHY && cnt_q == 5'(PHYAD_W - 1)) begin
            cnt_d = '0;
            if ({sh_q[3:0], MDIO_OUT} == PHY_ADDR) begin
              state_d = S_REG;
            end else begin
              state_d = S_SKIP;
              cnt_d   = SKIP_AFTER_PHY;
            end
          end else if (state_q == S_REG && cnt_q == 5'(REGAD_W - 1)) begin
            cnt_d   = '0;
            regad_d = {sh_q[3:0], MDIO_OUT};
            state_d = S_TA;
          end
        end
      end
      S_TA: begin
        if (is_read_q) begin
          // cnt_q marks that the first TA rise has been seen; drive from the next fall.
          if (rise) begin
            cnt_d = 5'd1;
          end else if (fall && cnt_q != '0) begin
            slv_oe_d  = 1'b1;
            mdio_in_d = 1'b0;
            sh_d      = rd_word;
            cnt_d     = '0;
            state_d   = S_RDATA;
          end
        end else if (sample) begin
          if (cnt_q == 5'(TA_W - 1)) begin
            cnt_d   = '0;
            state_d = S_WDATA;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_WDATA: begin
        // cnt_q == DATA_W is the commit clk that follows the last data rise.
        if (cnt_q == 5'(DATA_W)) begin
          commit      = 1'b1;
          wr_strobe_d = 1'b1;
          wr_addr_d   = regad_q;
          wr_data_d   = sh_q;
          state_d     = S_IDLE;
        end else if (!MDIO_OE) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (sample) begin
          sh_d  = {sh_q[14:0], MDIO_OUT};
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_RDATA: begin
        if (rise) begin
          cnt_d = cnt_q + 5'd1;
        end else if (fall) begin
          if (cnt_q == RD_RISES) begin
            slv_oe_d  = 1'b0;
            mdio_in_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            mdio_in_d = sh_q[15];
            sh_d      = {sh_q[14:0], 1'b0};
          end
        end
      end
      S_SKIP: begin
        if (rise) begin
          if (cnt_q <= 5'd1) state_d = S_IDLE;
          else               cnt_d   = cnt_q - 5'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Register bank update on a committed write; reg0 bit15 clears every R/W register.
  always_comb begin
    regs_d = regs_q;
    if (commit) begin
      if (regad_q == 5'd0 && sh_q[15]) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) regs_d[i] = '0;
      end else if (regad_q != 5'd2 && regad_q != 5'd3 && {1'b0, regad_q} < NUM_REGS_L) begin
        regs_d[regad_q[IDXW-1:0]] = (regad_q == 5'd0) ? {1'b0, sh_q[14:0]} : sh_q;
      end
    end
  end

  // FSM and datapath state.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      hist_q      <= '1;
      is_read_q   <= 1'b0;
      regad_q     <= '0;
      mdio_in_q   <= 1'b1;
      slv_oe_q    <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      hist_q      <= hist_d;
      is_read_q   <= is_read_d;
      regad_q     <= regad_d;
      mdio_in_q   <= mdio_in_d;
      slv_oe_q    <= slv_oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register bank storage.
  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign MDIO_IN   = mdio_in_q;
  assign SLV_OE    = slv_oe_q;
  assign WR_STROBE = wr_strobe_q;
  assign WR_ADDR   = wr_addr_q;
  assign WR_DATA   = wr_data_q;
  assign FRAME_ERR = frame_err_q;

endmodule
